// File: rtl/div_pkg.sv
// ============================================================================
// Module  : div_pkg
// Purpose : Shared state encoding, widths and helpers for iter_div_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package div_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Two's-complement magnitude; the most negative value maps onto itself,
    // which is exactly its magnitude when read as unsigned.
    function automatic logic [DIV_W-1:0] abs_val(input logic [DIV_W-1:0] value,
                                                 input logic             is_signed);
        return (is_signed && value[DIV_W-1]) ? -value : value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module  : div_step
// Purpose : One combinational restoring radix-2 division step.
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   p_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH:0]   p_out,
    output logic [WIDTH-1:0] a_out
);

    logic [WIDTH:0]   p_sh;
    logic [WIDTH-1:0] a_sh;

    always_comb begin
        p_sh  = {p_in[WIDTH-1:0], a_in[WIDTH-1]};
        a_sh  = {a_in[WIDTH-2:0], 1'b0};
        p_out = p_sh;
        a_out = a_sh;
        if (p_sh >= {1'b0, d_in}) begin
            p_out = p_sh - {1'b0, d_in};
            a_out = {a_sh[WIDTH-1:1], 1'b1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/iter_div_unit.sv
// ============================================================================
// Module  : iter_div_unit
// Purpose : Multi-cycle signed/unsigned restoring divider with valid/ready.
//           Optional DIV_EARLY_OUT_EN short-cuts |rm| >= |rn| operations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module iter_div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] rn,
    input  logic [WIDTH-1:0] rm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_zero
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     part_q, part_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               neg_quot_q, neg_quot_d;
    logic               neg_rem_q, neg_rem_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               div_zero_q, div_zero_d;
`ifdef DIV_EARLY_OUT_EN
    logic [WIDTH-1:0]   rn_orig_q, rn_orig_d;
`endif

    logic [WIDTH:0]     step_p;
    logic [WIDTH-1:0]   step_a;

    div_step #(.WIDTH(WIDTH)) u_step (
        .p_in  (part_q),
        .a_in  (dvd_q),
        .d_in  (dvs_q),
        .p_out (step_p),
        .a_out (step_a)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        part_d      = part_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        neg_quot_d  = neg_quot_q;
        neg_rem_d   = neg_rem_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        div_zero_d  = div_zero_q;
`ifdef DIV_EARLY_OUT_EN
        rn_orig_d   = rn_orig_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    in_ready_d = 1'b0;
                    if (rn == '0 || rm == '0) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        quot_d      = '0;
                        rem_d       = '0;
                        div_zero_d  = (rm == '0);
                    end else begin
                        state_d    = ITER;
                        cnt_d      = '0;
                        part_d     = '0;
                        dvd_d      = abs_val(rn, is_signed);
                        dvs_d      = abs_val(rm, is_signed);
                        neg_quot_d = is_signed & (rn[WIDTH-1] ^ rm[WIDTH-1]);
                        neg_rem_d  = is_signed & rn[WIDTH-1];
`ifdef DIV_EARLY_OUT_EN
                        rn_orig_d  = rn;
`endif
                    end
                end
            end
            ITER: begin
                state_d = ITER;
                part_d  = step_p;
                dvd_d   = step_a;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1))
                    state_d = FIX;
`ifdef DIV_EARLY_OUT_EN
                // First ITER cycle doubles as the magnitude comparison slot.
                if (cnt_q == '0 && dvs_q >= dvd_q) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    div_zero_d  = 1'b0;
                    if (dvs_q > dvd_q) begin
                        quot_d = '0;
                        rem_d  = rn_orig_q;
                    end else begin
                        quot_d = neg_quot_q ? '1 : WIDTH'(1);
                        rem_d  = '0;
                    end
                end
`endif
            end
            FIX: begin
                state_d     = DONE;
                out_valid_d = 1'b1;
                div_zero_d  = 1'b0;
                quot_d      = neg_quot_q ? -dvd_q : dvd_q;
                rem_d       = neg_rem_q ? -part_q[WIDTH-1:0] : part_q[WIDTH-1:0];
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            part_q      <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            div_zero_q  <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
            rn_orig_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            part_q      <= part_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            neg_quot_q  <= neg_quot_d;
            neg_rem_q   <= neg_rem_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            div_zero_q  <= div_zero_d;
`ifdef DIV_EARLY_OUT_EN
            rn_orig_q   <= rn_orig_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quot      = quot_q;
    assign rem       = rem_q;
    assign div_zero  = div_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_iter_div_unit.sv
// ============================================================================
// Module  : tb_iter_div_unit
// Purpose : Self-checking bench for iter_div_unit against an arithmetic model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_iter_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        is_signed = 1'b0;
    logic [31:0] rn = '0;
    logic [31:0] rm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_zero;

    int n_checks = 0;
    int n_errors = 0;

    iter_div_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_signed (is_signed),
        .rn        (rn),
        .rm        (rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // Reference: truncating division on 64-bit integers, remainder follows the dividend.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic dz, output int lat);
        longint sa, sb, aa, ab;
        sa = s ? longint'($signed(a)) : longint'({32'd0, a});
        sb = s ? longint'($signed(b)) : longint'({32'd0, b});
        dz = (b == 32'd0);
        if (a == 32'd0 || b == 32'd0) begin
            q = 32'd0; r = 32'd0; lat = 1;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            aa = (sa < 0) ? -sa : sa;
            ab = (sb < 0) ? -sb : sb;
            lat = 34;
`ifdef DIV_EARLY_OUT_EN
            if (ab >= aa) lat = 2;
`endif
        end
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                          output logic [31:0] q, output logic [31:0] r,
                          output logic dz, output int lat);
        @(negedge clk);
        in_valid = 1'b1; rn = a; rm = b; is_signed = s;
        @(posedge clk); #1;
        in_valid = 1'b0; rn = $urandom; rm = $urandom; is_signed = 1'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        q = quot; r = rem; dz = div_zero;
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, out_valid, div_zero} !== 3'b100) begin
            n_errors++;
            $display("FAIL reset_flags got ir/ov/dz=%b required 100", {in_ready, out_valid, div_zero});
        end
        n_checks++;
        if (quot !== 32'd0 || rem !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_data got q=%h r=%h required 0/0", quot, rem);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] ta [7], tb [7], eq [7], er [7];
        bit          ts [7];
        logic        ez [7];
        int          el [7];
        logic [31:0] q, r;
        logic        dz;
        int          lat;
        ta = '{32'hFFFFFFF4, 32'hFFFFFFF4, 32'hFFFFFFF9, 32'h00001234, 32'h00000000, 32'h80000000, 32'hFFFFFFFF};
        tb = '{32'h2,        32'h2,        32'h2,        32'h0,        32'h5,        32'hFFFFFFFF, 32'h10};
        ts = '{1'b1,         1'b0,         1'b1,         1'b0,         1'b1,         1'b1,         1'b0};
        eq = '{32'hFFFFFFFA, 32'h7FFFFFFA, 32'hFFFFFFFD, 32'h0,        32'h0,        32'h80000000, 32'h0FFFFFFF};
        er = '{32'h0,        32'h0,        32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        32'hF};
        ez = '{1'b0,         1'b0,         1'b0,         1'b1,         1'b0,         1'b0,         1'b0};
        el = '{34,           34,           34,           1,            1,            34,           34};
        for (int i = 0; i < 7; i++) begin
            run_op(ta[i], tb[i], ts[i], q, r, dz, lat);
            n_checks++;
            if (q !== eq[i] || r !== er[i] || dz !== ez[i]) begin
                n_errors++;
                $display("FAIL directed[%0d] got q=%h r=%h dz=%b required q=%h r=%h dz=%b",
                         i, q, r, dz, eq[i], er[i], ez[i]);
            end
`ifndef DIV_EARLY_OUT_EN
            n_checks++;
            if (lat != el[i]) begin
                n_errors++;
                $display("FAIL directed_latency[%0d] got %0d required %0d", i, lat, el[i]);
            end
`endif
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, q, r, mq, mr;
        logic        dz, mz;
        int          lat, ml;
        bit          s;
        for (int i = 0; i < 24; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = $urandom_range(1, 100);
                3:       b = -32'($urandom_range(1, 100));
                default: b = $urandom;
            endcase
            s = 1'($urandom);
            ref_div(a, b, s, mq, mr, mz, ml);
            run_op(a, b, s, q, r, dz, lat);
            n_checks++;
            if (q !== mq || r !== mr || dz !== mz || lat != ml) begin
                n_errors++;
                $display("FAIL random[%0d] %h/%h s=%b got q=%h r=%h dz=%b lat=%0d required q=%h r=%h dz=%b lat=%0d",
                         i, a, b, s, q, r, dz, lat, mq, mr, mz, ml);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        in_valid = 1'b1; rn = 32'd100; rm = 32'd7; is_signed = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; rn = 32'd50; rm = 32'd3; is_signed = 1'b0;
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, in_ready, quot, rem} !== {1'b1, 1'b0, 32'd14, 32'd2}) begin
                n_errors++;
                $display("FAIL hold[%0d] got ov=%b ir=%b q=%h r=%h required ov=1 ir=0 q=e r=2",
                         i, out_valid, in_ready, quot, rem);
            end
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL release got ir=%b ov=%b required ir=1 ov=0", in_ready, out_valid);
        end
        @(negedge clk); out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (quot !== 32'd16 || rem !== 32'd2 || lat != 34) begin
            n_errors++;
            $display("FAIL queued_op got q=%h r=%h lat=%0d required q=10 r=2 lat=34", quot, rem, lat);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_iter();
        logic [31:0] q, r;
        logic        dz;
        int          lat;
        @(negedge clk);
        in_valid = 1'b1; rn = 32'hDEADBEEF; rm = 32'd3; is_signed = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready, quot, rem} !== {1'b0, 1'b1, 32'd0, 32'd0}) begin
            n_errors++;
            $display("FAIL mid_reset got ov=%b ir=%b q=%h r=%h required ov=0 ir=1 q=0 r=0",
                     out_valid, in_ready, quot, rem);
        end
        @(negedge clk); rst_n = 1'b1;
        run_op(32'd100, 32'd7, 1'b0, q, r, dz, lat);
        n_checks++;
        if (q !== 32'd14 || r !== 32'd2 || dz !== 1'b0) begin
            n_errors++;
            $display("FAIL after_reset got q=%h r=%h dz=%b required q=e r=2 dz=0", q, r, dz);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_iter();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
